// File: rtl/arb_8t1_32.sv
// Registered 8-to-1 round-robin collector for 32-bit words.
// One grant per accept opportunity; the winner's word lands in a single output register.
module arb_8t1_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  req,
    input  logic [31:0] d_arr [7:0],
    output logic [7:0]  gnt,
    output logic [31:0] y,
    output logic [2:0]  y_src,
    output logic        y_valid,
    input  logic        y_ready
);

    localparam int unsigned N_LANES = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = 3;

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [IDX_W-1:0]  y_src_q, y_src_d;
    logic              y_valid_q, y_valid_d;

    logic              can_accept_c;
    logic              win_hit_c;
    logic [IDX_W-1:0]  win_idx_c;
    logic [IDX_W-1:0]  lane_c;

    assign can_accept_c = ~y_valid_q | y_ready;

    // Rotating priority search starting at ptr; grant suppressed by reset or a full, stalled output.
    always_comb begin
        win_hit_c = 1'b0;
        win_idx_c = '0;
        lane_c    = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            lane_c = IDX_W'(ptr_q + IDX_W'(i));
            if (!win_hit_c && req[lane_c]) begin
                win_hit_c = 1'b1;
                win_idx_c = lane_c;
            end
        end
        if (rst || !can_accept_c) begin
            win_hit_c = 1'b0;
        end
        gnt = win_hit_c ? (N_LANES'(1) << win_idx_c) : '0;
    end

    // Next state: capture on grant (overwriting a word draining this cycle), else drain.
    always_comb begin
        ptr_d     = ptr_q;
        y_d       = y_q;
        y_src_d   = y_src_q;
        y_valid_d = y_valid_q;
        if (win_hit_c) begin
            ptr_d     = IDX_W'(win_idx_c + IDX_W'(1));
            y_d       = d_arr[win_idx_c];
            y_src_d   = win_idx_c;
            y_valid_d = 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            y_q       <= '0;
            y_src_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            y_q       <= y_d;
            y_src_q   <= y_src_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_src   = y_src_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_arb_8t1_32.sv
// Directed self-checking bench for arb_8t1_32: reset, round-robin wrap, sparse
// requests, backpressure, drain and mid-stream reset.
module tb_arb_8t1_32;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [31:0] d_arr [7:0];
    logic [7:0]  gnt;
    logic [31:0] y;
    logic [2:0]  y_src;
    logic        y_valid;
    logic        y_ready;

    int n_cmp = 0;
    int n_err = 0;

    arb_8t1_32 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d_arr   (d_arr),
        .gnt     (gnt),
        .y       (y),
        .y_src   (y_src),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  gexp;
        logic [2:0]  sexp;

        rst     = 1'b1;
        req     = 8'hFF;
        y_ready = 1'b1;
        for (int i = 0; i < 8; i++) d_arr[i] = 32'hA000_0000 + 32'(i);

        // Reset held two edges with everyone requesting
        #1;
        chk("rst_gnt0", 32'(gnt), 32'h0);
        step();
        chk("rst_gnt1", 32'(gnt), 32'h0);
        step();
        chk("rst_gnt2", 32'(gnt), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_y_valid", 32'(y_valid), 32'h0);
        chk("rst_y", y, 32'h0);
        chk("rst_y_src", 32'(y_src), 32'h0);
        chk("post_rst_gnt", 32'(gnt), 32'h01);
        step();
        chk("post_rst_y", y, 32'hA000_0000);
        chk("post_rst_src", 32'(y_src), 32'h0);

        // Round-robin continues 1..7,0,1
        for (int i = 1; i < 10; i++) begin
            sexp = 3'(i % 8);
            gexp = 8'h01 << sexp;
            chk("rr_gnt", 32'(gnt), 32'(gexp));
            step();
            chk("rr_src", 32'(y_src), 32'(sexp));
            chk("rr_y", y, 32'hA000_0000 + 32'(sexp));
            chk("rr_valid", 32'(y_valid), 32'h1);
        end

        // Move ptr to 0 via a lane-7 grant
        req = 8'h80;
        #1;
        chk("p0_gnt", 32'(gnt), 32'h80);
        step();
        chk("p0_src", 32'(y_src), 32'h7);

        // Sparse: lanes 2 and 7
        req = 8'b1000_0100;
        #1;
        chk("sp_gnt_a", 32'(gnt), 32'h04);
        step();
        chk("sp_src_a", 32'(y_src), 32'h2);
        chk("sp_y_a", y, 32'hA000_0002);
        chk("sp_gnt_b", 32'(gnt), 32'h80);
        step();
        chk("sp_src_b", 32'(y_src), 32'h7);
        req = 8'h01;
        #1;
        chk("sp_gnt_c", 32'(gnt), 32'h01);
        step();
        chk("sp_src_c", 32'(y_src), 32'h0);

        // Drain without refill
        req = 8'h00;
        #1;
        chk("dr_gnt", 32'(gnt), 32'h0);
        step();
        chk("dr_valid", 32'(y_valid), 32'h0);
        chk("dr_y", y, 32'hA000_0000);
        chk("dr_src", 32'(y_src), 32'h0);

        // Backpressure on lane 1
        req      = 8'h02;
        d_arr[1] = 32'hDEAD_BEEF;
        y_ready  = 1'b0;
        #1;
        chk("bp_gnt_first", 32'(gnt), 32'h02);
        step();
        chk("bp_y_first", y, 32'hDEAD_BEEF);
        chk("bp_src_first", 32'(y_src), 32'h1);
        d_arr[1] = 32'hCAFE_0001;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_gnt", 32'(gnt), 32'h0);
            step();
            chk("bp_hold_y", y, 32'hDEAD_BEEF);
            chk("bp_hold_valid", 32'(y_valid), 32'h1);
        end
        y_ready = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt), 32'h02);
        step();
        chk("bp_next_y", y, 32'hCAFE_0001);
        chk("bp_next_valid", 32'(y_valid), 32'h1);

        // Reset while lane 5's word sits undelivered
        req      = 8'h20;
        d_arr[5] = 32'h5555_5555;
        #1;
        chk("mr_gnt5", 32'(gnt), 32'h20);
        step();
        chk("mr_src5", 32'(y_src), 32'h5);
        y_ready = 1'b0;
        req     = 8'h01;
        rst     = 1'b1;
        #1;
        chk("mr_rst_gnt", 32'(gnt), 32'h0);
        step();
        chk("mr_valid", 32'(y_valid), 32'h0);
        chk("mr_y", y, 32'h0);
        chk("mr_src", 32'(y_src), 32'h0);
        rst     = 1'b0;
        y_ready = 1'b1;
        req     = 8'h21;
        #1;
        chk("mr_first_gnt", 32'(gnt), 32'h01);
        step();
        chk("mr_first_y", y, 32'hA000_0000);
        chk("mr_second_gnt", 32'(gnt), 32'h20);
        step();
        chk("mr_second_y", y, 32'h5555_5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_8t1_32.md
# arb_8t1_32

Registered 8-to-1 collector for 32-bit words; the gathering counterpart of the 1-to-8 demux. Eight producers each raise a request with a word. A round-robin arbiter picks one per cycle, captures its word into a single output register, and reports which lane it came from. The lane index has the same encoding as the demux select. The block sits wherever several pipeline lanes share one 32-bit destination, e.g. eight result sources contending for one writeback/result bus.

## Interface
- No parameters. Width fixed at 32, lane count fixed at 8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  req[i] = lane i holds a valid word on d_arr[i].
- d_arr  input  32 x [7:0]  per-lane data, unpacked array d_arr[7:0].
- gnt  output  8  one-hot or zero; gnt[i] = lane i's word is accepted at this clock edge.
- y  output  32  registered output word.
- y_src  output  3  lane index of y; 0..7 matching demux select s.
- y_valid  output  1  y/y_src hold an undelivered word.
- y_ready  input  1  downstream accepts y this cycle.

## Operation
- Lane handshake:
  - Producer holds req[i] and d_arr[i] stable until it sees gnt[i]=1 at a rising edge.
  - The transfer occurs at that edge.
  - Producer may drop req or present a new word the cycle after.
- Output handshake:
  - Transfer occurs when y_valid & y_ready at the edge.
  - y, y_src, y_valid are stable while y_valid & ~y_ready.
- Accept condition:
  - can_accept = ~y_valid | y_ready.
  - gnt is all-zero when ~can_accept, when req==0, or when rst=1.
- Arbitration:
  - 3-bit pointer ptr names the highest-priority lane.
  - Search order is ptr, ptr+1, ..., ptr+7 mod 8.
  - The first requesting lane wins.
- Pointer update:
  - On a grant to lane k, ptr <= (k+1) mod 8; wrap 7 -> 0.
  - No grant: ptr holds.
- Capture on grant to lane k: y <= d_arr[k], y_src <= k, y_valid <= 1.
- Drain without grant: y_valid <= 0. y and y_src hold their last values.
- Simultaneous drain and grant: new word replaces old, y_valid stays 1. This gives 1 word/cycle throughput.
- Combinational path: gnt depends on req, ptr, y_valid, y_ready. This is the only path from y_ready to an output; no path from d_arr to gnt.
- Fairness:
  - With all 8 lanes continuously requesting and y_ready=1, grants cycle 0,1,...,7,0.
  - Any requesting lane is granted within 8 accept opportunities.

## Timing
- Reset (rst=1 at an edge): y=0, y_src=0, y_valid=0, ptr=0. gnt=0 during every cycle rst is high.
- Reset mid-transfer: the word in the output register is discarded. A lane that was requesting is not granted while rst=1 and must keep requesting.
- Latency: the word granted at edge N appears on y with y_valid=1 from edge N until delivered; 1 cycle req-to-output when y_ready is continuously high.
- Backpressure:
  - Output full and y_ready=0: no grants, ptr frozen, requests wait.
  - When y_ready rises, a grant issues in that same cycle.
- Single lane requesting: granted every accept opportunity regardless of ptr.
- No internal buffering beyond the one output register; no words are lost or duplicated.

## Test plan
- Reset:
  - Stimulus: assert rst 2 cycles with req=8'hFF, y_ready=1.
  - Response: gnt=0 throughout; after release y_valid=0, y=0, y_src=0.
  - Next cycle: gnt=8'h01, and the following cycle shows y=d_arr[0], y_src=0.
- Round-robin wrap:
  - Stimulus: d_arr[i]=32'hA000_0000+i, req=8'hFF, y_ready=1 for 10 cycles.
  - Response: y_src sequence 0,1,...,7,0,1; y matches 32'hA000_000i.
- Sparse requests:
  - Stimulus: ptr=0, req=8'b1000_0100.
  - Response: gnt=8'h04 (y_src=2), then gnt=8'h80 (y_src=7); ptr wraps to 0.
  - Then req=8'h01 gives gnt=8'h01.
- Backpressure:
  - Stimulus: req=8'h02, d_arr[1]=32'hDEAD_BEEF, y_ready=0.
  - Response: one grant; y=32'hDEAD_BEEF, y_valid=1 held 5 cycles with gnt=0.
  - On y_ready=1, the same-cycle gnt=8'h02 captures the next word; no bubble.
- Drain without refill:
  - Stimulus: y_valid=1, req=0, y_ready=1.
  - Response: y_valid=0 next cycle; y and y_src unchanged.
- Reset mid-stream:
  - Stimulus: rst pulsed while y_valid=1, y_ready=0, y_src=5.
  - Response: y_valid=0, ptr=0, y=0; pending lane 5 word not delivered; lane 0 is first granted afterward if requesting.
